// File: rtl/scandoubler_pkg.sv
// Shared types and defaults for the scandoubler mode controller.
package scandoubler_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } lock_state_e;

  localparam logic [1:0] FM_AUTO   = 2'b00;
  localparam logic [1:0] FM_BYPASS = 2'b01;
  localparam logic [1:0] FM_DOUBLE = 2'b10;

  localparam int TOL_DEF          = 4;
  localparam int LOCK_LINES_DEF   = 8;
  localparam int LOST_LINES_DEF   = 4;
  localparam int HFREQ_THRESH_DEF = 1536;

endpackage

// File: rtl/sync_period_lock.sv
// Line-period measurement and SEARCH/MEASURE/LOCKED line-rate lock with
// sync-loss timeout on counter saturation.
module sync_period_lock
  import scandoubler_pkg::*;
#(
  parameter int LINE_W     = 12,
  parameter int TOL        = TOL_DEF,
  parameter int LOCK_LINES = LOCK_LINES_DEF,
  parameter int LOST_LINES = LOST_LINES_DEF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              hs_in,
  output logic              hs_fall,
  output logic              timeout,
  output logic              locked,
  output logic [LINE_W-1:0] line_len
);
  localparam int CNT_W = 8;
  localparam logic [LINE_W-1:0] HCNT_MAX  = '1;
  localparam logic [LINE_W-1:0] HCNT_TO   = {{(LINE_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(LOCK_LINES - 1);
  localparam logic [CNT_W-1:0]  LOST_LAST = CNT_W'(LOST_LINES - 1);
  localparam logic [LINE_W:0]   TOL_W     = (LINE_W+1)'(TOL);

  lock_state_e       state_q, state_d;
  logic              hs_q;
  logic [LINE_W-1:0] hcnt_q, hcnt_d, ref_len_q, ref_len_d, line_len_q, line_len_d;
  logic [CNT_W-1:0]  match_cnt_q, match_cnt_d, miss_cnt_q, miss_cnt_d;
  logic              locked_q, locked_d, match;
  logic [LINE_W:0]   period, ref_ext, diff;

  always_comb begin
    hs_fall = hs_q & ~hs_in;
    // Fires once, on the cycle the counter steps into saturation.
    timeout = ~hs_fall && (hcnt_q == HCNT_TO);
    period  = {1'b0, hcnt_q} + (LINE_W+1)'(1);
    ref_ext = {1'b0, ref_len_q};
    diff    = (period >= ref_ext) ? period - ref_ext : ref_ext - period;
    match   = (diff <= TOL_W);

    hcnt_d = hs_fall ? '0 : ((hcnt_q == HCNT_MAX) ? hcnt_q : hcnt_q + LINE_W'(1));

    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    ref_len_d   = ref_len_q;
    line_len_d  = line_len_q;
    locked_d    = locked_q;

    if (timeout) begin
      state_d     = SEARCH;
      locked_d    = 1'b0;
      match_cnt_d = '0;
      miss_cnt_d  = '0;
    end else if (hs_fall) begin
      case (state_q)
        SEARCH: begin
          state_d     = MEASURE;
          match_cnt_d = '0;
        end
        MEASURE: begin
          if (match) begin
            if (match_cnt_q == LOCK_LAST) begin
              state_d     = LOCKED;
              locked_d    = 1'b1;
              line_len_d  = ref_len_q;
              match_cnt_d = '0;
              miss_cnt_d  = '0;
            end else begin
              match_cnt_d = match_cnt_q + CNT_W'(1);
            end
          end else begin
            ref_len_d   = period[LINE_W] ? HCNT_MAX : period[LINE_W-1:0];
            match_cnt_d = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            miss_cnt_d = '0;
          end else if (miss_cnt_q == LOST_LAST) begin
            state_d    = SEARCH;
            locked_d   = 1'b0;
            miss_cnt_d = '0;
          end else begin
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= SEARCH;
      hs_q        <= 1'b0;
      hcnt_q      <= '0;
      ref_len_q   <= '0;
      line_len_q  <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hs_q        <= hs_in;
      hcnt_q      <= hcnt_d;
      ref_len_q   <= ref_len_d;
      line_len_q  <= line_len_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
    end
  end

  assign locked   = locked_q;
  assign line_len = line_len_q;

endmodule

// File: rtl/scandoubler_ctrl.sv
// Scandoubler mode controller: lock tracking, line counting per frame and
// frame-aligned selection between doubler and bypass output.
module scandoubler_ctrl
  import scandoubler_pkg::*;
#(
  parameter int LINE_W       = 12,
  parameter int TOL          = TOL_DEF,
  parameter int LOCK_LINES   = LOCK_LINES_DEF,
  parameter int LOST_LINES   = LOST_LINES_DEF,
  parameter int HFREQ_THRESH = HFREQ_THRESH_DEF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic [1:0]        force_mode,
  input  logic [1:0]        scanlines_cfg,
  output logic              sd_enable,
  output logic [1:0]        scanlines,
  output logic              locked,
  output logic [LINE_W-1:0] line_len,
  output logic [9:0]        lines_per_frame,
  output logic              mode_changed
);
  localparam logic [LINE_W-1:0] THRESH   = LINE_W'(HFREQ_THRESH);
  localparam logic [9:0]        VCNT_MAX = '1;

  logic       hs_fall, timeout, vs_fall, is_auto, want_double;
  logic       vs_q, sd_q, sd_d, sd_dly_q, mc_q, mc_d;
  logic [9:0] vcnt_q, vcnt_d, lpf_q, lpf_d;
  logic [1:0] scan_q, scan_d;

  sync_period_lock #(
    .LINE_W    (LINE_W),
    .TOL       (TOL),
    .LOCK_LINES(LOCK_LINES),
    .LOST_LINES(LOST_LINES)
  ) u_lock (
    .clk_sys (clk_sys),
    .reset   (reset),
    .hs_in   (hs_in),
    .hs_fall (hs_fall),
    .timeout (timeout),
    .locked  (locked),
    .line_len(line_len)
  );

  always_comb begin
    vs_fall     = vs_q & ~vs_in;
    is_auto     = (force_mode != FM_BYPASS) && (force_mode != FM_DOUBLE);
    want_double = 1'b0;
    case (force_mode)
      FM_DOUBLE: want_double = 1'b1;
      FM_BYPASS: want_double = 1'b0;
      default:   want_double = locked && (line_len > THRESH);
    endcase

    // A line starting together with vsync belongs to the new frame.
    vcnt_d = vcnt_q;
    lpf_d  = lpf_q;
    if (vs_fall) begin
      lpf_d  = vcnt_q;
      vcnt_d = hs_fall ? 10'd1 : 10'd0;
    end else if (hs_fall && (vcnt_q != VCNT_MAX)) begin
      vcnt_d = vcnt_q + 10'd1;
    end

    // Source loss in auto falls back to bypass at once; otherwise wait for vsync.
    sd_d = sd_q;
    if (timeout && is_auto) sd_d = 1'b0;
    else if (vs_fall)       sd_d = want_double;

    mc_d   = sd_q ^ sd_dly_q;
    scan_d = sd_q ? scanlines_cfg : 2'b00;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      vs_q     <= 1'b0;
      vcnt_q   <= '0;
      lpf_q    <= '0;
      sd_q     <= 1'b0;
      sd_dly_q <= 1'b0;
      mc_q     <= 1'b0;
      scan_q   <= '0;
    end else begin
      vs_q     <= vs_in;
      vcnt_q   <= vcnt_d;
      lpf_q    <= lpf_d;
      sd_q     <= sd_d;
      sd_dly_q <= sd_q;
      mc_q     <= mc_d;
      scan_q   <= scan_d;
    end
  end

  assign sd_enable       = sd_q;
  assign scanlines       = scan_q;
  assign lines_per_frame = lpf_q;
  assign mode_changed    = mc_q;

endmodule
